control_registro: RTL

- Sequencer for the parameterised shift register (`registro`) in the shift-register block.
- Accepts one job at a time over a valid/ready request port, drives the register's D/MODO/ENB/DIR/ITER pins, and pulses DONE when the job finishes.
- A job is a parallel load followed by N shift cycles:
  - Serial transmit uses PUSH mode; data leaves on the register's S_OUT.
  - Rotate uses CYCLE mode with ITER=0.

---
 rtl/control_registro_pkg.sv | 25 ++
 rtl/control_registro.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/control_registro_pkg.sv
// control_registro_pkg
//   Shared definitions for the shift-register block.
//   - MODO encodings understood by registro: `PUSH, `CYCLE, `LOAD.
//   - State encodings of the control_registro sequencer: CTRL_IDLE, CTRL_LOAD,
//     CTRL_SHIFT, CTRL_FIN.
//   The mode macros are guarded so that this file can be read before any other
//   file of the block that also relies on them.
`ifndef CONTROL_REGISTRO_DEFS
`define CONTROL_REGISTRO_DEFS
`define PUSH  2'b00
`define CYCLE 2'b01
`define LOAD  2'b10
`endif

package control_registro_pkg;

    // Binary-encoded sequencer states.
    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_LOAD  = 2'd1,
        CTRL_SHIFT = 2'd2,
        CTRL_FIN   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/control_registro.sv
// control_registro
//   Sequencer for the parameterised shift register (registro). Accepts one job
//   at a time, runs it as one parallel load followed by N shift cycles, and
//   pulses DONE when the job finishes.
//
//   Request handshake: a job transfers on a rising CLK edge where REQ_VALID and
//   REQ_READY are both high. REQ_READY is high only in IDLE, so a requester must
//   hold REQ_VALID (and the REQ_* fields) until it sees REQ_READY; REQ_VALID
//   while BUSY is ignored.
//
//   Parameters
//     WIDTH  register width, must match the driven registro instance
//     CNT_W  width of REQ_COUNT and the shift counter (>= clog2(WIDTH+1))
//
//   Ports
//     CLK, RESET            clock, asynchronous active-high reset
//     REQ_VALID/REQ_READY   job request handshake
//     REQ_OP                0 = serial transmit (PUSH), 1 = rotate (CYCLE, ITER=0)
//     REQ_DIR               shift direction, forwarded to R_DIR
//     REQ_DATA              word to load
//     REQ_COUNT             number of shift cycles, 0 means WIDTH
//     ABORT                 synchronous job cancel (LOAD/SHIFT only)
//     PAUSE                 shift stall, present only with CTRL_PAUSE_EN
//     R_D/R_MODO/R_ENB/R_DIR/R_ITER   registro control pins
//     BUSY                  high in any state other than IDLE
//     DONE                  one-cycle completion pulse
//
//   Build option: define CTRL_PAUSE_EN to add the PAUSE input. PAUSE=1 in SHIFT
//   drops R_ENB and freezes the counter; ABORT still wins over PAUSE.
module control_registro
    import control_registro_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_OP,
    input  logic             REQ_DIR,
    input  logic [WIDTH-1:0] REQ_DATA,
    input  logic [CNT_W-1:0] REQ_COUNT,
    input  logic             ABORT,
`ifdef CTRL_PAUSE_EN
    input  logic             PAUSE,
`endif
    output logic [WIDTH-1:0] R_D,
    output logic [1:0]       R_MODO,
    output logic             R_ENB,
    output logic             R_DIR,
    output logic             R_ITER,
    output logic             BUSY,
    output logic             DONE
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             job_op_q;
    logic             job_dir_q;
    logic [WIDTH-1:0] job_data_q;
    logic [CNT_W-1:0] job_cnt_q;
    logic [CNT_W-1:0] shift_cnt_q;
    logic             accept;
    logic             stall;

`ifdef CTRL_PAUSE_EN
    assign stall = PAUSE;
`else
    assign stall = 1'b0;
`endif

    // Acceptance depends only on being in IDLE, so ABORT in IDLE never blocks it.
    assign accept = (state_q == CTRL_IDLE) && REQ_VALID;

    // State register and latched job fields.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= CTRL_IDLE;
            job_op_q    <= 1'b0;
            job_dir_q   <= 1'b0;
            job_data_q  <= '0;
            job_cnt_q   <= '0;
            shift_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                job_op_q   <= REQ_OP;
                job_dir_q  <= REQ_DIR;
                job_data_q <= REQ_DATA;
                job_cnt_q  <= (REQ_COUNT == '0) ? CNT_W'(WIDTH) : REQ_COUNT;
            end
            // The counter is armed while leaving LOAD and runs only in
            // unstalled SHIFT cycles, so it always equals the shifts left.
            if (state_q == CTRL_LOAD) begin
                shift_cnt_q <= job_cnt_q;
            end else if ((state_q == CTRL_SHIFT) && !stall) begin
                shift_cnt_q <= shift_cnt_q - CNT_W'(1);
            end
        end
    end

    // Next-state logic. ABORT is checked before PAUSE and before the counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_IDLE: begin
                if (REQ_VALID) state_d = CTRL_LOAD;
            end
            CTRL_LOAD: begin
                state_d = ABORT ? CTRL_IDLE : CTRL_SHIFT;
            end
            CTRL_SHIFT: begin
                if (ABORT) begin
                    state_d = CTRL_IDLE;
                end else if (!stall && (shift_cnt_q == CNT_W'(1))) begin
                    state_d = CTRL_FIN;
                end
            end
            CTRL_FIN: begin
                state_d = CTRL_IDLE;
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    // Output decode from state and latched job registers only; no REQ_* input
    // reaches an R_* pin in the same cycle.
    always_comb begin
        REQ_READY = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        R_ENB     = 1'b0;
        R_MODO    = `LOAD;
        R_DIR     = job_dir_q;
        R_ITER    = 1'b0;
        R_D       = job_data_q;
        case (state_q)
            CTRL_IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
            end
            CTRL_LOAD: begin
                R_ENB = 1'b1;
            end
            CTRL_SHIFT: begin
                R_ENB  = !stall;
                R_MODO = job_op_q ? `CYCLE : `PUSH;
            end
            CTRL_FIN: begin
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b1;
            end
        endcase
    end

endmodule
